// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO link poller: bridge address layout, BMSR constants,
// address builder and FSM state types.
package mdio_pkg;

  localparam int ADDR_REG_LSB = 1;
  localparam int ADDR_PHY_LSB = 7;
  localparam int ADDR_BUS_LSB = 12;

  localparam logic [4:0]  BMSR_REG       = 5'd1;
  localparam int          BMSR_LINK_BIT  = 2;
  localparam logic [15:0] ABSENT_PATTERN = 16'hFFFF;

  typedef enum logic [1:0] {P_IDLE, P_ARB, P_XFER, P_NEXT} poll_state_e;
  typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_state_e;

  // Bridge address {bus[3:0], phy[4:0], 1'b0, reg[4:0], 1'b0}
  function automatic logic [15:0] mk_paddr(input logic [3:0] bus, input logic [4:0] phy,
                                           input logic [4:0] regad);
    logic [15:0] a;
    a = '0;
    a[ADDR_BUS_LSB +: 4] = bus;
    a[ADDR_PHY_LSB +: 5] = phy;
    a[ADDR_REG_LSB +: 5] = regad;
    return a;
  endfunction

endpackage

// File: rtl/mdio_apb_master.sv
// APB3 transfer sequencer: latches a request on start_i, runs SETUP then ACCESS until
// pready, and flags completion with done_o in the cycle pready is sampled.
module mdio_apb_master
  import mdio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] addr_i,
  input  logic        wr_i,
  input  logic [15:0] wdata_i,
  output logic        done_o,
  output logic [15:0] rdata_o,
  output logic [15:0] paddr_o,
  output logic        pwrite_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic [15:0] pwdata_o,
  input  logic [15:0] prdata_i,
  input  logic        pready_i
);

  apb_state_e  state_q, state_d;
  logic [15:0] addr_q, wdata_q;
  logic        wr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= A_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == A_IDLE && start_i) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        wr_q    <= wr_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    case (state_q)
      A_IDLE:   if (start_i) state_d = A_SETUP;
      A_SETUP:  state_d = A_ACCESS;
      A_ACCESS: begin
        if (pready_i) begin
          done_o  = 1'b1;
          state_d = A_IDLE;
        end
      end
      default:  state_d = A_IDLE;
    endcase
  end

  // Strobes come straight from the state register so rst drops them immediately
  assign psel_o    = (state_q != A_IDLE);
  assign penable_o = (state_q == A_ACCESS);
  assign paddr_o   = addr_q;
  assign pwrite_o  = wr_q;
  assign pwdata_o  = wdata_q;
  assign rdata_o   = prdata_i;

endmodule

// File: rtl/mdio_link_poller.sv
// Autonomous BMSR poller with host pass-through sharing one APB master.
// Optional macro LINK_DEBOUNCE_EN: link_up changes only after two agreeing sweeps.
module mdio_link_poller
  import mdio_pkg::*;
#(
  parameter int                     NUM_PORTS = 5,
  parameter logic [9*NUM_PORTS-1:0] PORT_MAP  = {4'd4, 5'd1, 4'd3, 5'd1, 4'd2, 5'd1,
                                                 4'd1, 5'd1, 4'd0, 5'd1},
  parameter int                     POLL_GAP  = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 poll_now,
  input  logic                 host_req,
  input  logic                 host_wr,
  input  logic [15:0]          host_addr,
  input  logic [15:0]          host_wdata,
  output logic [15:0]          host_rdata,
  output logic                 host_ack,
  output logic [15:0]          paddr,
  output logic                 pwrite,
  output logic                 psel,
  output logic                 penable,
  output logic [15:0]          pwdata,
  input  logic [15:0]          prdata,
  input  logic                 pready,
  output logic [NUM_PORTS-1:0] link_up,
  output logic [NUM_PORTS-1:0] absent,
  output logic                 link_chg,
  output logic                 irq,
  input  logic                 irq_clr
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  poll_state_e          state_q, state_d;
  logic [31:0]          gap_q, gap_d;
  logic [IDX_W-1:0]     entry_q, entry_d;
  logic                 read_q, read_d;
  logic                 sweep_q, sweep_d;
  logic                 pending_q, pending_d;
  logic                 host_sel_q, host_sel_d;
  logic                 host_ack_q, host_ack_d;
  logic [15:0]          host_rdata_q, host_rdata_d;
  logic [NUM_PORTS-1:0] link_q, link_d, absent_q, absent_d;
  logic                 link_chg_q, irq_q;

  logic        m_start, m_wr, m_done;
  logic [15:0] m_addr, m_wdata, m_rdata;
  logic        result_vld, res_absent, res_link;
  logic [15:0] port_addr [NUM_PORTS];

  mdio_apb_master u_master (
    .clk       (clk),
    .rst       (rst),
    .start_i   (m_start),
    .addr_i    (m_addr),
    .wr_i      (m_wr),
    .wdata_i   (m_wdata),
    .done_o    (m_done),
    .rdata_o   (m_rdata),
    .paddr_o   (paddr),
    .pwrite_o  (pwrite),
    .psel_o    (psel),
    .penable_o (penable),
    .pwdata_o  (pwdata),
    .prdata_i  (prdata),
    .pready_i  (pready)
  );

  assign res_absent = (m_rdata == ABSENT_PATTERN);
  assign res_link   = m_rdata[BMSR_LINK_BIT] & ~res_absent;

`ifdef LINK_DEBOUNCE_EN
  logic [NUM_PORTS-1:0] cand_q, cand_d;
`endif

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic hit;
    assign port_addr[gi] = mk_paddr(PORT_MAP[gi*9+5 +: 4], PORT_MAP[gi*9 +: 5], BMSR_REG);
    assign hit           = result_vld && (entry_q == IDX_W'(gi));
    assign absent_d[gi]  = hit ? res_absent : absent_q[gi];
`ifdef LINK_DEBOUNCE_EN
    // Candidate holds the previous sweep's reading; a change needs two agreeing sweeps
    assign cand_d[gi] = hit ? res_link : cand_q[gi];
    assign link_d[gi] = (hit && (res_link != link_q[gi]) && (res_link == cand_q[gi]))
                        ? res_link : link_q[gi];
`else
    assign link_d[gi] = hit ? res_link : link_q[gi];
`endif
  end

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    entry_d      = entry_q;
    read_d       = read_q;
    sweep_d      = sweep_q;
    pending_d    = pending_q | poll_now;
    host_sel_d   = host_sel_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    result_vld   = 1'b0;
    m_start      = 1'b0;
    m_addr       = port_addr[entry_q];
    m_wr         = 1'b0;
    m_wdata      = '0;
    case (state_q)
      P_IDLE: begin
        if (enable && (gap_q == '0 || pending_d)) begin
          sweep_d   = 1'b1;
          entry_d   = '0;
          read_d    = 1'b0;
          pending_d = 1'b0;
          state_d   = P_ARB;
        end else begin
          if (enable) gap_d = gap_q - 32'd1;
          if (host_req) state_d = P_ARB;
        end
      end
      P_ARB: begin
        if (host_req) begin
          m_start    = 1'b1;
          m_addr     = host_addr;
          m_wr       = host_wr;
          m_wdata    = host_wdata;
          host_sel_d = 1'b1;
          state_d    = P_XFER;
        end else if (sweep_q && enable) begin
          m_start    = 1'b1;
          host_sel_d = 1'b0;
          state_d    = P_XFER;
        end else begin
          sweep_d = 1'b0;
          state_d = P_IDLE;
        end
      end
      P_XFER: begin
        if (m_done) begin
          state_d = P_NEXT;
          if (host_sel_q) begin
            host_ack_d   = 1'b1;
            host_rdata_d = pwrite ? 16'h0000 : m_rdata;
          end else if (!read_q) begin
            read_d = 1'b1;
          end else begin
            result_vld = 1'b1;
            read_d     = 1'b0;
            if (entry_q == IDX_W'(NUM_PORTS - 1)) begin
              gap_d   = 32'(POLL_GAP);
              entry_d = '0;
              if (pending_d) pending_d = 1'b0;
              else           sweep_d   = 1'b0;
            end else begin
              entry_d = entry_q + IDX_W'(1);
            end
          end
        end
      end
      P_NEXT:  state_d = (sweep_q || host_req) ? P_ARB : P_IDLE;
      default: state_d = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= P_IDLE;
      gap_q        <= '0;
      entry_q      <= '0;
      read_q       <= 1'b0;
      sweep_q      <= 1'b0;
      pending_q    <= 1'b0;
      host_sel_q   <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      link_q       <= '0;
      absent_q     <= '0;
      link_chg_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      entry_q      <= entry_d;
      read_q       <= read_d;
      sweep_q      <= sweep_d;
      pending_q    <= pending_d;
      host_sel_q   <= host_sel_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
      link_q       <= link_d;
      absent_q     <= absent_d;
      link_chg_q   <= |(link_d ^ link_q);
      // Set beats clear when both land in the same cycle
      irq_q        <= link_chg_q | (irq_q & ~irq_clr);
    end
  end

`ifdef LINK_DEBOUNCE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cand_q <= '0;
    else     cand_q <= cand_d;
  end
`endif

  assign host_rdata = host_rdata_q;
  assign host_ack   = host_ack_q;
  assign link_up    = link_q;
  assign absent     = absent_q;
  assign link_chg   = link_chg_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_mdio_link_poller.sv
// Directed bench for mdio_link_poller with a 5-cycle-pready bridge model and POLL_GAP=20.
`timescale 1ns/1ps
module tb_mdio_link_poller;
`ifdef LINK_DEBOUNCE_EN
  localparam int NSW = 2;
`else
  localparam int NSW = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0, poll_now = 1'b0, irq_clr = 1'b0;
  logic        host_req = 1'b0, host_wr = 1'b0;
  logic [15:0] host_addr = '0, host_wdata = '0;
  logic [15:0] host_rdata, paddr, pwdata, prdata;
  logic        host_ack, pwrite, psel, penable, pready, link_chg, irq;
  logic [4:0]  link_up, absent;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdio_link_poller #(.NUM_PORTS(5), .POLL_GAP(20)) dut (
    .clk(clk), .rst(rst), .enable(enable), .poll_now(poll_now),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .prdata(prdata), .pready(pready),
    .link_up(link_up), .absent(absent), .link_chg(link_chg), .irq(irq), .irq_clr(irq_clr)
  );

  // Bridge model: BMSR reads of bus 0..4 return rd1/rd2 alternately per entry
  logic [15:0] rd1 [8];
  logic [15:0] rd2 [8];
  logic [7:0]  par;
  logic [2:0]  wcnt;
  logic [15:0] host_addr_seen = '0, wr_data_seen = '0, setup_addr = '0;
  logic [15:0] addr_log [16];
  logic        prev_end;
  int          rd_cnt = 0, chg_cnt = 0, viol = 0, xfer_idx = 0;

  wire  [2:0]  m_idx   = paddr[14:12];
  wire         is_poll = !pwrite && (paddr[5:1] == 5'd1) && (paddr[15:12] < 4'd5);

  assign pready = psel && penable && (wcnt == 3'd4);

  always_comb begin
    prdata = 16'h0000;
    if (pready) begin
      if (is_poll) prdata = par[m_idx] ? rd2[m_idx] : rd1[m_idx];
      else         prdata = pwrite ? 16'hDEAD : 16'hBEEF;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      wcnt     <= '0;
      par      <= '0;
      prev_end <= 1'b0;
    end else begin
      wcnt     <= (psel && penable && !pready) ? wcnt + 3'd1 : 3'd0;
      prev_end <= psel && penable && pready;
      if (prev_end && psel) viol <= viol + 1;
      if (psel && penable && paddr != setup_addr) viol <= viol + 1;
      if (psel && !penable) begin
        setup_addr <= paddr;
        if (xfer_idx < 16) addr_log[xfer_idx] <= paddr;
        xfer_idx <= xfer_idx + 1;
      end
      if (link_chg) chg_cnt <= chg_cnt + 1;
      if (pready) begin
        if (is_poll) begin
          par[m_idx] <= ~par[m_idx];
          rd_cnt     <= rd_cnt + 1;
        end else begin
          host_addr_seen <= paddr;
          if (pwrite) wr_data_seen <= pwdata;
        end
      end
    end
  end

  task automatic wait_reads(input int target, input string nm);
    int n = 0;
    while (rd_cnt < target && n < 1500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rd_cnt < target) begin
      failures++;
      $display("FAIL %s: poll reads %0d, required %0d", nm, rd_cnt, target);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({psel, penable, link_chg, irq, host_ack, link_up, absent, host_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: psel=%b penable=%b link_up=%b absent=%b irq=%b ack=%b",
               psel, penable, link_up, absent, irq, host_ack);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (psel !== 1'b0) begin
      failures++;
      $display("FAIL idle_disabled: psel=%b required 0", psel);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_link_up();
    int c0 = chg_cnt;
    rd1[2] = 16'h0004;
    rd2[2] = 16'h0004;
    enable = 1'b1;
    wait_reads(10 * NSW, "sweep1_done");
    repeat (2) @(negedge clk);
    checks++;
    if (link_up !== 5'b00100) begin failures++; $display("FAIL link_up_e2: got %b want 00100", link_up); end
    checks++;
    if (chg_cnt - c0 !== 1) begin failures++; $display("FAIL chg_pulses: got %0d want 1", chg_cnt - c0); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_set: got %b want 1", irq); end
    checks++;
    if (addr_log[0] !== 16'h0082 || addr_log[1] !== 16'h0082) begin
      failures++;
      $display("FAIL paddr_e0: got %h/%h want 0082/0082", addr_log[0], addr_log[1]);
    end
    checks++;
    if (addr_log[2] !== 16'h1082 || addr_log[9] !== 16'h4082) begin
      failures++;
      $display("FAIL paddr_e1_e4: got %h/%h want 1082/4082", addr_log[2], addr_log[9]);
    end
    $display("link_up: link_up=%b irq=%b", link_up, irq);
  endtask

  task automatic test_latched_low();
    int base = rd_cnt;
    rd1[0] = 16'h0000;
    rd2[0] = 16'h0004;
    wait_reads(base + 10 * NSW, "latched_sweep");
    repeat (2) @(negedge clk);
    checks++;
    if (link_up !== 5'b00101) begin failures++; $display("FAIL latched_low: got %b want 00101", link_up); end
    $display("latched_low: link_up=%b", link_up);
  endtask

  task automatic test_absent_irq();
    int base;
    int n = 0;
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear: got %b want 0", irq); end
    base = rd_cnt;
    rd1[4] = 16'h0004;
    rd2[4] = 16'h0004;
    wait_reads(base + 10 * NSW, "e4_up_sweep");
    repeat (2) @(negedge clk);
    checks++;
    if (link_up !== 5'b10101) begin failures++; $display("FAIL e4_up: got %b want 10101", link_up); end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    base = rd_cnt;
    rd1[4] = 16'hFFFF;
    rd2[4] = 16'hFFFF;
    while (link_chg !== 1'b1 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_set_wins: got %b want 1 (waited %0d)", irq, n); end
    wait_reads(base + 10 * NSW, "absent_sweep");
    @(negedge clk);
    checks++;
    if (absent !== 5'b10000 || link_up !== 5'b00101) begin
      failures++;
      $display("FAIL absent_e4: absent=%b link_up=%b want 10000/00101", absent, link_up);
    end
    $display("absent_irq: absent=%b link_up=%b irq=%b", absent, link_up, irq);
  endtask

  task automatic test_host();
    int base = rd_cnt;
    int r0;
    int n = 0;
    wait_reads(base + 1, "host_sweep_start");
    repeat (3) @(negedge clk);
    r0 = rd_cnt;
    host_req = 1'b1;
    host_wr = 1'b0;
    host_addr = 16'h7184;
    while (host_ack !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (host_ack !== 1'b1 || host_rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL host_read: ack=%b rdata=%h want 1/beef", host_ack, host_rdata);
    end
    checks++;
    if (rd_cnt - r0 !== 1) begin failures++; $display("FAIL host_wait: poll reads before ack %0d want 1", rd_cnt - r0); end
    checks++;
    if (host_addr_seen !== 16'h7184) begin failures++; $display("FAIL host_addr: got %h want 7184", host_addr_seen); end
    host_wr = 1'b1;
    host_wdata = 16'h1200;
    @(negedge clk);
    checks++;
    if (host_ack !== 1'b0) begin failures++; $display("FAIL ack_width: got %b want 0", host_ack); end
    n = 0;
    while (host_ack !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    host_req = 1'b0;
    checks++;
    if (host_ack !== 1'b1 || host_rdata !== 16'h0000 || wr_data_seen !== 16'h1200) begin
      failures++;
      $display("FAIL host_write: ack=%b rdata=%h wdata=%h want 1/0000/1200", host_ack, host_rdata, wr_data_seen);
    end
    wait_reads(base + 10 * NSW, "host_sweep_resume");
    @(negedge clk);
    checks++;
    if (link_up !== 5'b00101) begin failures++; $display("FAIL resume_link: got %b want 00101", link_up); end
    $display("host: read %h, write done, link_up=%b", 16'hBEEF, link_up);
  endtask

  task automatic test_debounce();
    logic seq [6];
    logic expv [6];
    int base;
    seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef LINK_DEBOUNCE_EN
    expv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    expv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
    for (int k = 0; k < 6; k++) begin
      base = rd_cnt;
      rd1[3] = seq[k] ? 16'h0004 : 16'h0000;
      rd2[3] = rd1[3];
      wait_reads(base + 10, "debounce_sweep");
      @(negedge clk);
      checks++;
      if (link_up[3] !== expv[k]) begin
        failures++;
        $display("FAIL debounce_%0d: link_up[3]=%b want %b", k, link_up[3], expv[k]);
      end
      $display("debounce: sweep %0d read %b link_up[3]=%b", k, seq[k], link_up[3]);
    end
  endtask

  task automatic test_back_to_back();
    int base = rd_cnt;
    int n = 0;
    wait_reads(base + 10, "gap_sweep");
    while (psel !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n < 20 || n > 40) begin failures++; $display("FAIL normal_gap: %0d cycles want 20..40", n); end
    base = rd_cnt;
    repeat (4) @(negedge clk);
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    wait_reads(base + 10, "b2b_sweep");
    n = 0;
    while (psel !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n > 4 || paddr !== 16'h0082) begin
      failures++;
      $display("FAIL back_to_back: gap %0d cycles paddr %h want <=4/0082", n, paddr);
    end
    checks++;
    if (viol !== 0) begin failures++; $display("FAIL apb_protocol: violations %0d want 0", viol); end
    $display("back_to_back: restart after %0d cycles", n);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (penable !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (penable !== 1'b1 || irq !== 1'b1 || link_up === 5'b00000) begin
      failures++;
      $display("FAIL pre_reset: penable=%b irq=%b link_up=%b want 1/1/nonzero", penable, irq, link_up);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({psel, penable, irq, link_up} !== '0) begin
      failures++;
      $display("FAIL async_reset: psel=%b penable=%b irq=%b link_up=%b want all 0", psel, penable, irq, link_up);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({psel, absent, host_ack} !== '0) begin
      failures++;
      $display("FAIL post_reset: psel=%b absent=%b ack=%b want 0", psel, absent, host_ack);
    end
    $display("reset_mid: outputs cleared");
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rd1[i] = 16'h7809;
      rd2[i] = 16'h7809;
    end
    test_reset();
    test_link_up();
    test_latched_low();
    test_absent_irq();
    test_host();
    test_debounce();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
